sum_seg7_display: RTL
=====================

Name: sum_seg7_display

Overview:
- Downstream consumer of the 16-bit memory-sum accumulator on the BASYS3 board.
- Captures a 16-bit binary sum on a load pulse and converts it to four BCD digits with a sequential double-dabble engine, one shift per cycle.
- Time-multiplexes the digits onto the board's 4-digit common-anode seven-segment display.
- Values above 9999 are flagged as overflow and shown as dashes.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); must be >= 2.
- SUM_W, 16, width of the input sum.

Ports:
- clock  input  1  system clock; all logic on posedge.
- clear  input  1  synchronous, active-high reset.
- sum_in  input  SUM_W  binary value to display.
- load  input  1  single-cycle request to capture sum_in.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the display register updates.
- an  output  4  digit anodes, active-low; an[0] is the ones digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; held 1 (off).

Behaviour:
- Reset (clear=1 at posedge, regardless of state):
  - state=IDLE; busy=0; done=0.
  - Display digit register = 0000; overflow flag = 0.
  - Refresh counter = 0; digit_sel = 0.
  - an=4'b1110; seg=7'b1000000 ('0'); dp=1.
  - An in-progress conversion is abandoned and its result is never latched.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE:
  - load=1 at posedge: capture sum_in into the shift register, clear the 16-bit BCD scratch, set iter=0, go to SHIFT.
  - busy=1 from the next cycle.
- SHIFT:
  - Each cycle: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1; iter++.
  - After the 16th shift (iter==15 at that edge), go to LATCH.
  - The scratch is 20 bits (5 nibbles), because 65535 needs 5 digits.
- LATCH:
  - Write the low 4 nibbles to the display register.
  - overflow = (ten-thousands nibble != 0).
  - done=1 for this cycle only; go to IDLE; busy=0 on the following cycle.
- Latency: load sampled at edge N; busy high for edges N+1..N+17; display register and done valid after edge N+17.
  - A load asserted at the first edge after done is accepted.
- load while busy: ignored (no queueing).
  - sum_in is only sampled at the IDLE acceptance edge.
  - Later changes to sum_in do not affect the running conversion.
- The display register holds the previous value throughout a conversion (no partial or torn digits).
- Multiplexing:
  - Refresh counter counts 0..REFRESH_DIV-1; on wrap, digit_sel increments mod 4 (0→1→2→3→0).
  - an is the one-hot-low of digit_sel.
  - seg decodes the selected nibble and is registered together with an, so both change on the same edge.
  - Multiplexing runs continuously, independent of FSM state.
- Overflow: all four digits show dash (seg=7'b0111111, g only lit).
- Nibble values 10-15 cannot occur in BCD; the decoder maps them to blank (7'b1111111).

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Leading zero digits above the ones digit are blanked (seg=7'b1111111 while that anode is active).
  - Value 0 shows a single '0' on digit 0.
  - Blank flags are computed in LATCH and stored with the display register.
  - Overflow dashes are never blanked.
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - FSM state enum (IDLE, SHIFT, LATCH).
  - Segment constants: SEG_DIGIT[0..9], SEG_DASH, SEG_BLANK.
  - BCD_DIGITS=5, DISP_DIGITS=4.
- Sub-module seg7_decoder: purely combinational nibble-to-segment lookup using the package constants. It is instantiated once, on the selected digit.

Test Plan (bench uses REFRESH_DIV=4):
1. Reset:
   - Assert clear for 2 cycles, then release.
   - Expect: busy=0, done=0, an=1110, seg=1000000, dp=1.
   - an rotates 1110→1101→1011→0111 every 4 cycles.
2. Basic load:
   - load=1 with sum_in=16'd1234.
   - Expect: busy high for 17 cycles, done pulses once.
   - Digit slots show ones=4 (0011001), tens=3 (0110000), hundreds=2 (0100100), thousands=1 (1111001).
3. Boundaries:
   - sum_in=9999 → all slots 0010000.
   - sum_in=10000 → overflow, all slots 0111111.
   - sum_in=65535 → overflow dashes.
4. Load while busy:
   - load 0042, then pulse load with 0777 five cycles later.
   - Expect: only one done; display shows 0042.
   - With SEG7_LEADING_ZERO_BLANK_EN defined: digits 3 and 2 are blank and the display shows "42".
5. Reset mid-conversion:
   - Display holds 1234; load 5678; assert clear at cycle 8 of SHIFT.
   - Expect: display 0000, busy=0, no done pulse.
   - A subsequent load 0005 completes normally in 17 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the sum-to-seven-segment display path.
// Contents: FSM state enum, segment glyph constants ({g,f,e,d,c,b,a}, active-low),
// digit-count localparams, the display payload struct, and the double-dabble
// nibble-adjust helper.
package seg7_pkg;

  localparam int unsigned BCD_DIGITS  = 5;
  localparam int unsigned DISP_DIGITS = 4;
  localparam int unsigned NIB_W       = 4;
  localparam int unsigned SEG_W       = 7;
  localparam int unsigned BCD_W       = BCD_DIGITS * NIB_W;
  localparam int unsigned DISP_W      = DISP_DIGITS * NIB_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [SEG_W-1:0] SEG_DIGIT [10] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Latched display contents: four BCD digits plus per-digit flags.
  typedef struct packed {
    logic [DISP_W-1:0]      digits;
    logic                   ovf;
    logic [DISP_DIGITS-1:0] blank;
  } disp_t;

  // Double-dabble pre-shift correction: add 3 to every nibble >= 5.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (r[i*NIB_W +: NIB_W] >= 4'd5) begin
        r[i*NIB_W +: NIB_W] = r[i*NIB_W +: NIB_W] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to seven-segment glyph lookup.
// Ports:
//   nibble - BCD digit value (10..15 render blank)
//   seg_c  - segments {g,f,e,d,c,b,a}, active-low
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (nibble <= 4'd9) begin
      seg_c = SEG_DIGIT[nibble];
    end
  end

endmodule

// File: rtl/sum_seg7_display.sv
// Captures a binary sum on a load pulse, converts it to BCD with a serial
// double-dabble engine (one shift per clock), and time-multiplexes the four
// digits onto a common-anode seven-segment display. Values above 9999 show
// as dashes on all digits.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits
// above the ones digit.
// Ports:
//   clock  - system clock, posedge
//   clear  - synchronous active-high reset
//   sum_in - binary value to display, sampled only when a load is accepted
//   load   - single-cycle capture request, ignored while busy
//   busy   - conversion in progress
//   done   - one-cycle pulse when the display register updates
//   an     - digit anodes, active-low, an[0] = ones digit
//   seg    - segments {g,f,e,d,c,b,a}, active-low
//   dp     - decimal point, active-low, held off
module sum_seg7_display
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned SUM_W       = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int unsigned ITER_W = (SUM_W > 1) ? $clog2(SUM_W) : 1;
  localparam int unsigned REF_W  = $clog2(REFRESH_DIV);
  localparam int unsigned SEL_W  = $clog2(DISP_DIGITS);

  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(SUM_W - 1);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Reset value 0 shows only the ones digit.
  localparam logic [DISP_DIGITS-1:0] BLANK_RST = 4'b1110;
`else
  localparam logic [DISP_DIGITS-1:0] BLANK_RST = '0;
`endif

  localparam disp_t DISP_RST = '{digits: '0, ovf: 1'b0, blank: BLANK_RST};

  state_t             state, state_nxt;
  logic [SUM_W-1:0]   bin, bin_nxt;
  logic [BCD_W-1:0]   bcd, bcd_nxt;
  logic [ITER_W-1:0]  iter, iter_nxt;
  disp_t              disp, disp_nxt;
  logic               busy_nxt, done_nxt;

  logic [REF_W-1:0]   ref_cnt, ref_nxt;
  logic [SEL_W-1:0]   sel, sel_nxt;
  logic [3:0]         an_nxt;
  logic [SEG_W-1:0]   seg_nxt;
  logic [NIB_W-1:0]   nib_c;
  logic [SEG_W-1:0]   dec_seg_c;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic               lead_c;
`endif

  // Conversion FSM: next state plus datapath next values.
  always_comb begin
    state_nxt = state;
    bin_nxt   = bin;
    bcd_nxt   = bcd;
    iter_nxt  = iter;
    disp_nxt  = disp;
    done_nxt  = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lead_c    = 1'b1;
`endif
    case (state)
      IDLE: begin
        if (load) begin
          bin_nxt   = sum_in;
          bcd_nxt   = '0;
          iter_nxt  = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_nxt, bin_nxt} = {dd_adjust(bcd), bin} << 1;
        iter_nxt = iter + ITER_W'(1);
        if (iter == ITER_LAST) begin
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        disp_nxt.digits = bcd[DISP_W-1:0];
        disp_nxt.ovf    = |bcd[BCD_W-1:DISP_W];
        disp_nxt.blank  = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // Walk down from the top digit; a digit is blank while everything
        // above and including it is zero. Dashes are never blanked.
        for (int d = int'(DISP_DIGITS) - 1; d >= 1; d--) begin
          lead_c = lead_c && (bcd[d*NIB_W +: NIB_W] == 4'd0);
          disp_nxt.blank[d] = lead_c && !disp_nxt.ovf;
        end
`endif
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Refresh divider and digit select, free-running.
  always_comb begin
    ref_nxt = ref_cnt + REF_W'(1);
    sel_nxt = sel;
    if (ref_cnt == REF_LAST) begin
      ref_nxt = '0;
      sel_nxt = sel + SEL_W'(1);
    end
  end

  // Decode from next-cycle values so an/seg track the display register
  // and digit select on the same edge.
  assign nib_c = disp_nxt.digits[sel_nxt*NIB_W +: NIB_W];

  seg7_decoder u_dec (
    .nibble (nib_c),
    .seg_c  (dec_seg_c)
  );

  always_comb begin
    an_nxt  = ~(4'b0001 << sel_nxt);
    seg_nxt = dec_seg_c;
    if (disp_nxt.ovf) begin
      seg_nxt = SEG_DASH;
    end else if (disp_nxt.blank[sel_nxt]) begin
      seg_nxt = SEG_BLANK;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      bin     <= '0;
      bcd     <= '0;
      iter    <= '0;
      disp    <= DISP_RST;
      busy    <= 1'b0;
      done    <= 1'b0;
      ref_cnt <= '0;
      sel     <= '0;
      an      <= 4'b1110;
      seg     <= SEG_DIGIT[0];
      dp      <= 1'b1;
    end else begin
      state   <= state_nxt;
      bin     <= bin_nxt;
      bcd     <= bcd_nxt;
      iter    <= iter_nxt;
      disp    <= disp_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      ref_cnt <= ref_nxt;
      sel     <= sel_nxt;
      an      <= an_nxt;
      seg     <= seg_nxt;
      dp      <= 1'b1;
    end
  end

endmodule
